// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_prefetch_queue : IF front end, prefetch FIFO + pipelined imem requests.
// Optional static backward-taken prediction with FETCH_BTFN_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
  parameter int          QDEPTH    = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  input  logic                    flush_i,
  input  logic [31:0]             redirect_pc_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [31:0]             instr_o,
  output logic [31:0]             instr_pc_o,
  output logic                    pred_taken_o,
  output logic [$clog2(QDEPTH):0] q_count_o
);

  localparam int              AW          = $clog2(QDEPTH);
  localparam int              CW          = AW + 1;
  localparam logic [CW:0]     QDEPTH_EXT  = (CW+1)'(QDEPTH);
  localparam logic [CW-1:0]   MAX_OUTST_W = CW'(MAX_OUTST);

  // PCs are kept as word addresses so the low two bits are zero by construction.
  logic [29:0]   fetch_word_q, fetch_word_d;
  logic [29:0]   resp_word_q,  resp_word_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q,  drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   instr_mem_q [QDEPTH];
  logic [29:0]   pc_mem_q    [QDEPTH];
  logic          pred_mem_q  [QDEPTH];

  logic          resp_keep;
  logic          push;
  logic          pop;
  logic          issue;
  logic          pred_redirect;
  logic [29:0]   pred_target;
  logic [CW:0]   occupancy;
  logic [1:0]    unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc_i[1:0];

  assign resp_keep = mem_rvalid_i && (drop_q == '0);

`ifdef FETCH_BTFN_EN
  logic [29:0] b_imm_word;
  assign b_imm_word    = {{19{mem_rdata_i[31]}}, mem_rdata_i[31], mem_rdata_i[7],
                          mem_rdata_i[30:25], mem_rdata_i[11:9]};
  assign pred_redirect = resp_keep && !flush_i && mem_rdata_i[31] &&
                         (mem_rdata_i[6:0] == 7'b1100011);
  assign pred_target   = resp_word_q + b_imm_word;
`else
  assign pred_redirect = 1'b0;
  assign pred_target   = resp_word_q;
`endif

  // Every in-flight request owns a queue slot, so a response can always be pushed.
  assign occupancy  = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req_o  = !reset && !flush_i && !pred_redirect &&
                      (outst_q < MAX_OUTST_W) && (occupancy < QDEPTH_EXT);
  assign mem_addr_o = {fetch_word_q, 2'b00};
  assign issue      = mem_req_o && mem_gnt_i;

  assign instr_valid_o = (count_q != '0);
  assign push          = resp_keep && !flush_i;
  assign pop           = instr_valid_o && instr_ready_i && !flush_i;

  assign instr_o      = instr_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign instr_pc_o   = instr_valid_o ? {pc_mem_q[rd_ptr_q], 2'b00} : 32'h0;
  assign pred_taken_o = instr_valid_o && pred_mem_q[rd_ptr_q];
  assign q_count_o    = count_q;

  always_comb begin
    fetch_word_d = fetch_word_q;
    resp_word_d  = resp_word_q;
    outst_d      = outst_q;
    drop_d       = drop_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    if (flush_i) begin
      fetch_word_d = redirect_pc_i[31:2];
      resp_word_d  = redirect_pc_i[31:2];
      outst_d      = outst_q - CW'(mem_rvalid_i);
      drop_d       = outst_q - CW'(mem_rvalid_i);
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
    end else begin
      if (issue) begin
        fetch_word_d = fetch_word_q + 30'd1;
      end
      outst_d = outst_q + CW'(issue) - CW'(mem_rvalid_i);
      if (mem_rvalid_i && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d    = wr_ptr_q + AW'(1);
        resp_word_d = resp_word_q + 30'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // The predicted branch itself is kept; everything fetched after it is stale.
      if (pred_redirect) begin
        fetch_word_d = pred_target;
        resp_word_d  = pred_target;
        drop_d       = outst_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_word_q <= RESET_PC[31:2];
      resp_word_q  <= RESET_PC[31:2];
      outst_q      <= '0;
      drop_q       <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      fetch_word_q <= fetch_word_d;
      resp_word_q  <= resp_word_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Storage needs no reset: reads are gated by instr_valid_o.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= resp_word_q;
      pred_mem_q[wr_ptr_q]  <= pred_redirect;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// Bench for fetch_prefetch_queue: vector table, directed corner cases and a
// randomized run against a transaction-level queue model with a behavioural memory.
module tb_fetch_prefetch_queue;

  localparam int QD = 4;
  localparam int MO = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        pred_taken_o;
  logic [2:0]  q_count_o;

  fetch_prefetch_queue #(.QDEPTH(QD), .MAX_OUTST(MO), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .pred_taken_o(pred_taken_o),
    .q_count_o(q_count_o)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic pred; } ent_t;

  req_t pend[$];
  int   now      = 0;
  int   lat_min  = 1;
  int   lat_max  = 1;
  int   gnt_prob = 100;

  ent_t        m_q[$];
  logic [31:0] m_fetch, m_resp;
  int          m_outst, m_drop;

  logic        s_req, s_valid, s_pred;
  logic [31:0] s_addr, s_instr, s_pc;
  logic [2:0]  s_count;

  typedef struct {
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;
  vec_t vt[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'hFE0008E3;   // beq x0,x0,-16
    return {a[26:2], 7'h13};
  endfunction

`ifdef FETCH_BTFN_EN
  function automatic logic [31:0] bimm(input logic [31:0] d);
    return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
  endfunction
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    pend.delete();
    m_fetch = 32'h0;
    m_resp  = 32'h0;
    m_outst = 0;
    m_drop  = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    flush_i = 1'b0; redirect_pc_i = 32'h0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; instr_ready_i = 1'b0;
    repeat (2) @(posedge clock);
    #4;
    chk("rst_req",   {31'h0, mem_req_o},     32'h0);
    chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("rst_count", {29'h0, q_count_o},     32'h0);
    chk("rst_instr", instr_o,                32'h0);
    chk("rst_pc",    instr_pc_o,             32'h0);
    chk("rst_pred",  {31'h0, pred_taken_o},  32'h0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle, then advance.
  task automatic cycle(input logic rdy, input logic fl, input logic [31:0] rpc);
    logic        rv, g, acc, predr, exp_req, pop;
    logic [31:0] rd, t;
    int          d;
    ent_t        e;
    rv = (pend.size() > 0) && (pend[0].due <= now);
    rd = rv ? mem_word(pend[0].addr) : 32'h0;
    g  = ($urandom_range(99) < gnt_prob);
    mem_rvalid_i = rv; mem_rdata_i = rd; mem_gnt_i = g;
    instr_ready_i = rdy; flush_i = fl; redirect_pc_i = rpc;
    #4;
    acc   = rv && (m_drop == 0);
    predr = 1'b0;
`ifdef FETCH_BTFN_EN
    predr = acc && !fl && rd[31] && (rd[6:0] == 7'b1100011);
`endif
    exp_req = !fl && !predr && (m_outst < MO) && ((m_q.size() + m_outst) < QD);

    s_req = mem_req_o; s_addr = mem_addr_o; s_valid = instr_valid_o;
    s_instr = instr_o; s_pc = instr_pc_o; s_pred = pred_taken_o; s_count = q_count_o;

    chk("req",   {31'h0, s_req},   {31'h0, exp_req});
    if (exp_req) chk("addr", s_addr, m_fetch);
    chk("valid", {31'h0, s_valid}, {31'h0, (m_q.size() > 0)});
    chk("count", {29'h0, s_count}, m_q.size());
    if (m_q.size() > 0) begin
      chk("instr", s_instr, m_q[0].instr);
      chk("pc",    s_pc,    m_q[0].pc);
      chk("pred",  {31'h0, s_pred}, {31'h0, m_q[0].pred});
    end

    pop = (m_q.size() > 0) && rdy;
    if (fl) begin
      m_q.delete();
      m_outst = m_outst - int'(rv);
      m_drop  = m_outst;
      m_fetch = {rpc[31:2], 2'b00};
      m_resp  = m_fetch;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rv) begin
        m_outst--;
        if (m_drop > 0) m_drop--;
        else begin
          e.instr = rd; e.pc = m_resp; e.pred = predr;
          m_q.push_back(e);
          if (predr) begin
`ifdef FETCH_BTFN_EN
            t = m_resp + bimm(rd);
`else
            t = m_resp + 32'd4;
`endif
            m_fetch = {t[31:2], 2'b00};
            m_resp  = m_fetch;
            m_drop  = m_outst;
          end else m_resp = m_resp + 32'd4;
        end
      end
      if (exp_req && g) begin
        m_fetch = m_fetch + 32'd4;
        m_outst++;
      end
    end

    if (rv) void'(pend.pop_front());
    if (mem_req_o && g) begin
      d = now + $urandom_range(lat_max, lat_min);
      if (pend.size() > 0 && pend[$].due >= d) d = pend[$].due + 1;
      pend.push_back('{addr: mem_addr_o, due: d});
    end
    chk("outst_bound", pend.size() <= MO, 32'h1);
    now++;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    int          got;
    bit          hit;

    vt[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
    vt[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0};
    vt[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1};
    vt[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1};
    vt[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1};
    vt[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd1};
    vt[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 3'd1};
    vt[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2};
    vt[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 3'd3};
    vt[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 3'd4};
    vt[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 3'd4};

    reset = 1'b1;
    flush_i = 1'b0; redirect_pc_i = 32'h0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; instr_ready_i = 1'b0;

    // Zero-wait streaming then stall, from the vector table.
    lat_min = 1; lat_max = 1; gnt_prob = 100;
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      cycle(vt[i].rdy, 1'b0, 32'h0);
      chk($sformatf("vt%0d_req", i), {31'h0, s_req}, {31'h0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("vt%0d_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vt%0d_valid", i), {31'h0, s_valid}, {31'h0, vt[i].e_valid});
      if (vt[i].e_valid) chk($sformatf("vt%0d_pc", i), s_pc, vt[i].e_pc);
      chk($sformatf("vt%0d_count", i), {29'h0, s_count}, {29'h0, vt[i].e_cnt});
    end

    // Stall from reset: head holds at PC 0, queue saturates, then drains in order.
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (s_valid) chk("stall_head", s_pc, 32'h0);
    end
    chk("stall_count", {29'h0, s_count}, 32'd4);
    chk("stall_req",   {31'h0, s_req},   32'h0);
    exp_pc = 32'h0;
    got = 0;
    for (int i = 0; i < 40 && got < 8; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        chk("drain_pc", s_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    chk("drain_total", got, 32'd8);

    // 3-cycle memory latency.
    lat_min = 3; lat_max = 3;
    reset_dut();
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 32'h0);

    // Flush to 0x103 with two requests in flight.
    reset_dut();
    for (int i = 0; i < 10 && m_outst < 2; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("flush_inflight", m_outst, 32'd2);
    cycle(1'b1, 1'b1, 32'h103);
    cycle(1'b1, 1'b0, 32'h0);
    chk("flush_empty", {29'h0, s_count}, 32'h0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      hit = s_valid;
    end
    chk("flush_seen",  {31'h0, hit}, 32'h1);
    chk("flush_pc",    s_pc,    32'h100);
    chk("flush_instr", s_instr, mem_word(32'h100));

`ifdef FETCH_BTFN_EN
    // Backward branch at 0x20 predicted taken; the in-flight 0x24 is discarded.
    lat_min = 2; lat_max = 2;
    reset_dut();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      hit = s_valid && (s_pc == 32'h20);
    end
    chk("btfn_seen", {31'h0, hit}, 32'h1);
    chk("btfn_pred", {31'h0, s_pred}, 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      hit = s_valid;
    end
    chk("btfn_target", s_pc, 32'h10);

    // A flush in the prediction cycle wins.
    reset_dut();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      hit = (pend.size() > 0) && (pend[0].addr == 32'h20) && (pend[0].due <= now) && (m_drop == 0);
      if (!hit) cycle(1'b1, 1'b0, 32'h0);
    end
    chk("btfn_flush_arm", {31'h0, hit}, 32'h1);
    cycle(1'b1, 1'b1, 32'h24);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      hit = s_valid;
    end
    chk("btfn_flush_pc",   s_pc, 32'h24);
    chk("btfn_flush_pred", {31'h0, s_pred}, 32'h0);
`endif

    // Randomized traffic: latency, grants, stalls, flushes, address wrap, mid-run reset.
    lat_min = 1; lat_max = 4; gnt_prob = 70;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_dut();
      rpc = $urandom & 32'h0000_03FF;
      if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cycle($urandom_range(3) != 0, $urandom_range(99) < 3, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
